serial_magnitude_comparator: RTL
================================

# serial_magnitude_comparator

Bit-serial N-bit magnitude comparator that sits directly upstream of the `comparator_1_bit` cell in the OoO tag/operand compare path. It scans operand bits MSB-first, one per clock, and drives the 1-bit cell. It stops on the first unequal bit and registers a single greater/less/equal decision with a start/done handshake. Issue logic uses it for compares where area matters more than single-cycle latency.

## Interface
- `WIDTH`, 32: operand width in bits; ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `flush`  in  1  synchronous abort of an in-flight compare.
- `signed_mode`  in  1  1 = two's-complement compare; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a decision is registered.
- `a_gt`  out  1  A > B; held until the next accepted `start`.
- `b_gt`  out  1  B > A; held likewise.
- `eq`  out  1  A == B; held likewise.

## Operation
- Instantiates one `comparator_1_bit` (port order `enable, in1, in2, in1_greater, in2_greater, equal`).
  - Cell `enable` = 1 only in RUN.
  - Cell inputs = latched `a[idx]`, `b[idx]`.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `ready`=1.
  - On `start`=1, latch `a`, `b`, `signed_mode`; set `idx` = WIDTH-1; clear `a_gt`/`b_gt`/`eq`; go to RUN.
- RUN (one bit per cycle):
  - If the cell reports `equal`=0, register the decision and go to DONE.
  - Else if `idx`==0, set `eq`=1 and go to DONE.
  - Else decrement `idx`.
- Decision, unsigned: `a_gt` = cell `in1_greater`; `b_gt` = cell `in2_greater`.
- Decision, signed: when the deciding bit is `idx`==WIDTH-1, swap the sense (A MSB=1 means A negative, so `b_gt`=1). Lower bits decide unsigned-style.
- DONE:
  - `done`=1 for exactly this cycle.
  - Go to IDLE unconditionally.
  - `start` in DONE is ignored, because `ready`=0.
- Exactly one of `a_gt`/`b_gt`/`eq` is 1 after any completed compare. All three are 0 after reset, after a flush, and while a compare is in progress.
- `start` while not `ready` is ignored; the in-flight compare is unaffected.
- `flush`=1 in RUN or DONE:
  - Go to IDLE next edge; no `done` pulse.
  - `a_gt`/`b_gt`/`eq` = 0.
  - `flush` has priority over decision and over `start`.
  - `flush` in IDLE has no effect, and a simultaneous `start` is dropped.
- `rst` has priority over everything. It returns the FSM to IDLE from any state, including mid-RUN.
- `idx` width is $clog2(WIDTH). `idx` never underflows, because RUN exits at 0.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `a_gt`=0, `b_gt`=0, `eq`=0; state IDLE; `idx`=WIDTH-1.
- Acceptance: `start` is sampled at edge E0; `busy`=1 from E0.
- First differing bit i (or i=0 when equal): decision registered at edge E0+(WIDTH-i).
  - `done`, `a_gt`/`b_gt`/`eq` are visible in the following cycle.
  - `ready` returns at the next edge.
- Latency from the `start` edge to `done` high: best case 1 cycle (MSB differs), worst case WIDTH cycles.
- Minimum spacing between accepted starts = latency + 1 cycle.
- Results are registered outputs only; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a=0x80, b=0x7F, unsigned:
  - `done` 1 cycle after start; `a_gt`=1, `b_gt`=0, `eq`=0.
  - Same operands signed: `b_gt`=1.
- WIDTH=8, a=0x05, b=0x04: `done` 8 cycles after start; `a_gt`=1. Then a=b=0x3C: `done` after 8 cycles; `eq`=1, `a_gt`=`b_gt`=0.
- Signed a=0xFE (-2), b=0xFF (-1): decided at bit 0 after 8 cycles; `b_gt`=1.
- Start a=0x10, b=0x20; pulse `start` with a=0xFF, b=0x00 at cycle 2:
  - Second request ignored.
  - `done` at cycle 3 with `b_gt`=1.
  - `ready`=1 after; exactly one `done` pulse.
- Start a=0x01, b=0x02; assert `flush` at cycle 3: no `done`; all results 0; `ready`=1 next cycle. A new start then completes normally.
- Assert `rst` at cycle 4 of an 8-bit equal compare: all outputs return to reset values next cycle, and no `done` is produced.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: MSB-first bit-serial magnitude compare with start/done handshake
module comparator_1_bit (
    input  logic enable,
    input  logic in1,
    input  logic in2,
    output logic in1_greater,
    output logic in2_greater,
    output logic equal
);
    assign in1_greater = enable & in1 & ~in2;
    assign in2_greater = enable & ~in1 & in2;
    assign equal       = enable & ~(in1 ^ in2);
endmodule

module serial_magnitude_comparator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             a_gt,
    output logic             b_gt,
    output logic             eq
);
    localparam int IW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [IW-1:0] r_idx;
    logic r_signed, r_a_gt, r_b_gt, r_eq;
    logic w_in1_gt, w_in2_gt, w_equal, w_swap, w_accept, w_last;
    comparator_1_bit u_cell (
        .enable      (r_state == S_RUN),
        .in1         (r_a[r_idx]),
        .in2         (r_b[r_idx]),
        .in1_greater (w_in1_gt),
        .in2_greater (w_in2_gt),
        .equal       (w_equal)
    );
    // A set sign bit means negative, so a signed decision at the MSB flips sense
    assign w_swap   = r_signed & (r_idx == IW'(WIDTH - 1));
    assign w_accept = start & ~flush;
    assign w_last   = r_idx == '0;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_RUN : S_IDLE;
            S_RUN:   w_next = flush ? S_IDLE : (!w_equal || w_last) ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= IW'(WIDTH - 1);
            r_a_gt   <= 1'b0;
            r_b_gt   <= 1'b0;
            r_eq     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= signed_mode;
                r_idx    <= IW'(WIDTH - 1);
                r_a_gt   <= 1'b0;
                r_b_gt   <= 1'b0;
                r_eq     <= 1'b0;
            end
        end else if (flush) begin
            r_idx  <= IW'(WIDTH - 1);
            r_a_gt <= 1'b0;
            r_b_gt <= 1'b0;
            r_eq   <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (!w_equal) begin
                r_a_gt <= w_swap ? w_in2_gt : w_in1_gt;
                r_b_gt <= w_swap ? w_in1_gt : w_in2_gt;
            end else if (w_last) begin
                r_eq <= 1'b1;
            end else begin
                r_idx <= r_idx - IW'(1);
            end
        end
    end
    assign ready = r_state == S_IDLE;
    assign busy  = r_state == S_RUN;
    assign done  = r_state == S_DONE;
    assign a_gt  = r_a_gt;
    assign b_gt  = r_b_gt;
    assign eq    = r_eq;
endmodule
